// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath width and issue-stage FSM states.
// Imported by the command FIFO consumer and the issue stage top.
package alu_pkg;
    localparam int ALU_W = 4;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } issue_state_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of {op, a, b} commands; head is readable combinationally, updates one edge after push.
// Pushes when full and pops when empty are ignored; count is the sole full/empty indicator.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [1:0]               push_op,
    input  logic [W-1:0]             push_a,
    input  logic [W-1:0]             push_b,
    input  logic                     pop,
    output logic [1:0]               head_op,
    output logic [W-1:0]             head_a,
    output logic [W-1:0]             head_b,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + 2 * W;
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);
    assign {head_op, head_a, head_b} = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset: contents are only observed behind a non-zero count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {push_op, push_a, push_b};
    end
endmodule

// File: rtl/alu_issue_stage.sv
// Issues queued commands to a combinational ALU and registers its result behind a valid/ready handshake.
// One result per two cycles; in_ready depends only on FIFO occupancy, out_* freeze while stalled.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ALU_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    input  logic [1:0]             in_op,
    output logic [W-1:0]           alu_a,
    output logic [W-1:0]           alu_b,
    output logic [1:0]             alu_op,
    input  logic [W-1:0]           alu_result,
    input  logic                   alu_carry,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_result,
    output logic                   out_carry,
    output logic [1:0]             out_op,
    output logic [$clog2(DEPTH):0] count
);
    localparam logic [$clog2(DEPTH):0] FULL = DEPTH[$clog2(DEPTH):0];

    issue_state_t   state;
    logic           fifo_nonempty;
    logic           fifo_pop;
    logic [1:0]     head_op;
    logic [W-1:0]   head_a;
    logic [W-1:0]   head_b;

    assign in_ready      = count < FULL;
    assign fifo_nonempty = count != '0;
    assign fifo_pop      = fifo_nonempty &&
                           ((state == IDLE) || ((state == HOLD) && out_ready));

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid && in_ready),
        .push_op (in_op),
        .push_a  (in_a),
        .push_b  (in_b),
        .pop     (fifo_pop),
        .head_op (head_op),
        .head_a  (head_a),
        .head_b  (head_b),
        .count   (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_op     <= '0;
        end else begin
            if (fifo_pop) begin
                alu_op <= head_op;
                alu_a  <= head_a;
                alu_b  <= head_b;
            end
            unique case (state)
                IDLE: begin
                    if (fifo_nonempty) state <= EXEC;
                end
                // ALU has had a full cycle to settle on the registered operands.
                EXEC: begin
                    out_result <= alu_result;
                    out_carry  <= alu_carry;
                    out_op     <= alu_op;
                    out_valid  <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= fifo_nonempty ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, hand-written corner sequences,
// and randomized traffic scored against a queue-based reference of the ALU arithmetic.
module tb_alu_issue_stage;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_carry;
    logic [1:0] out_op;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;
    int n_in     = 0;
    int n_out    = 0;

    typedef struct {
        int op;
        int res;
        int cy;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       cy;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    // ALU behaviour from its definition: bit 4 is carry (ADD) or borrow (SUB).
    function automatic int alu_ref(input int op, input int a, input int b);
        case (op)
            0:       return a + b;
            1:       return ((a - b) & 15) | ((a < b) ? 16 : 0);
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    int alu_env;
    assign alu_env    = alu_ref(int'(alu_op), int'(alu_a), int'(alu_b));
    assign alu_result = alu_env[3:0];
    assign alu_carry  = alu_env[4];

    alu_issue_stage #(.DEPTH(DEPTH), .W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_op     (out_op),
        .count      (count)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sampled on the falling edge, away from every state change.
    logic       hold_prev = 1'b0;
    logic [3:0] held_res;
    logic       held_cy;
    logic [1:0] held_op;
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold_prev = 1'b0;
        end else begin
            chk("in_ready_vs_count", int'(in_ready), (int'(count) < DEPTH) ? 1 : 0);
            if (hold_prev) begin
                chk("stall_result_stable", int'(out_result), int'(held_res));
                chk("stall_carry_stable", int'(out_carry), int'(held_cy));
                chk("stall_op_stable", int'(out_op), int'(held_op));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("sb_result", int'(out_result), q[0].res);
                    chk("sb_carry", int'(out_carry), q[0].cy);
                    chk("sb_op", int'(out_op), q[0].op);
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                int r;
                r = alu_ref(int'(in_op), int'(in_a), int'(in_b));
                q.push_back('{int'(in_op), r % 16, r / 16});
                n_in++;
            end
            hold_prev = out_valid && !out_ready;
            held_res  = out_result;
            held_cy   = out_carry;
            held_op   = out_op;
        end
    end

    initial begin
        int base_in;
        int base_out;

        vecs[0] = '{2'd0, 4'd3,  4'd5,  4'd8,  1'b0};
        vecs[1] = '{2'd0, 4'd15, 4'd1,  4'd0,  1'b1};
        vecs[2] = '{2'd1, 4'd5,  4'd3,  4'd2,  1'b0};
        vecs[3] = '{2'd1, 4'd3,  4'd5,  4'd14, 1'b1};
        vecs[4] = '{2'd2, 4'd12, 4'd10, 4'd8,  1'b0};
        vecs[5] = '{2'd3, 4'd12, 4'd10, 4'd14, 1'b0};
        vecs[6] = '{2'd0, 4'd15, 4'd15, 4'd14, 1'b1};
        vecs[7] = '{2'd1, 4'd0,  4'd1,  4'd15, 1'b1};
        vecs[8] = '{2'd1, 4'd7,  4'd7,  4'd0,  1'b0};
        vecs[9] = '{2'd3, 4'd0,  4'd0,  4'd0,  1'b0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_result", int'(out_result), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_op", int'(alu_op), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single commands: latency and result from the vector table.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk("vec_count_after_push", int'(count), 1);
            chk("vec_valid_n", int'(out_valid), 0);
            step();
            chk("vec_valid_n1", int'(out_valid), 0);
            chk("vec_alu_a", int'(alu_a), int'(vecs[i].a));
            chk("vec_alu_b", int'(alu_b), int'(vecs[i].b));
            step();
            chk("vec_valid_n2", int'(out_valid), 1);
            chk("vec_result", int'(out_result), int'(vecs[i].res));
            chk("vec_carry", int'(out_carry), int'(vecs[i].cy));
            chk("vec_op", int'(out_op), int'(vecs[i].op));
            step();
            chk("vec_valid_drop", int'(out_valid), 0);
        end

        // Back-to-back ADD 15,1 then SUB 5,3: results two cycles apart.
        in_op = 2'd0; in_a = 4'd15; in_b = 4'd1; in_valid = 1'b1;
        step();
        in_op = 2'd1; in_a = 4'd5; in_b = 4'd3;
        step();
        in_valid = 1'b0;
        chk("b2b_valid_n1", int'(out_valid), 0);
        step();
        chk("b2b_first_valid", int'(out_valid), 1);
        chk("b2b_first_result", int'(out_result), 0);
        chk("b2b_first_carry", int'(out_carry), 1);
        step();
        chk("b2b_gap", int'(out_valid), 0);
        step();
        chk("b2b_second_valid", int'(out_valid), 1);
        chk("b2b_second_result", int'(out_result), 2);
        chk("b2b_second_carry", int'(out_carry), 0);
        step();
        chk("b2b_done", int'(out_valid), 0);

        // Stall downstream and push continuously: 1 in flight plus DEPTH queued.
        out_ready = 1'b0;
        base_in = n_in;
        for (int i = 0; i < 10; i++) begin
            in_op = 2'($urandom_range(0, 3)); in_a = 4'($urandom); in_b = 4'($urandom);
            in_valid = 1'b1;
            step();
        end
        chk("full_accepted", n_in - base_in, 5);
        chk("full_count", int'(count), 4);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_out_valid", int'(out_valid), 1);

        // Push while full coincident with an output handshake: push refused, count drops by one.
        base_out = n_out;
        out_ready = 1'b1;
        #1;
        chk("full_hs_in_ready", int'(in_ready), 0);
        step();
        in_valid = 1'b0;
        chk("full_hs_count", int'(count), 3);
        chk("full_hs_refused", n_in - base_in, 5);
        for (int k = 0; k < 40 && (n_out - base_out) < 5; k++) step();
        chk("full_drained", n_out - base_out, 5);
        step();
        chk("full_queue_empty", q.size(), 0);
        chk("full_idle_valid", int'(out_valid), 0);

        // Reset while holding a result with three commands queued.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_op = 2'($urandom_range(0, 3)); in_a = 4'($urandom); in_b = 4'($urandom);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("prerst_count", int'(count), 3);
        chk("prerst_valid", int'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_count", int'(count), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_result", int'(out_result), 0);
        @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("postrst_no_output", int'(out_valid), 0);
        end
        chk("postrst_count", int'(count), 0);

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 9) < 6);
            in_op = 2'($urandom_range(0, 3)); in_a = 4'($urandom); in_b = 4'($urandom);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 60 && (q.size() != 0 || out_valid); k++) step();
        chk("rand_drained", q.size(), 0);
        chk("rand_final_valid", int'(out_valid), 0);
        chk("rand_final_count", int'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
